stream_fifo_v3: RTL and testbench



---
 rtl/stream_fifo_v3_pkg.sv | 10 +
 rtl/stream_fifo_v3_fifo_core.sv | 106 ++++++++++
 rtl/stream_fifo_v3.sv | 80 ++++++++
 tb/tb_stream_fifo_v3.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_v3_pkg.sv
// Purpose : shared helpers for the stream_fifo_v3 block.
// Contents: addr_depth() - pointer width for a given entry count, never
//           narrower than one bit so a single-entry FIFO still has a pointer.
package stream_fifo_v3_pkg;

    function automatic int addr_depth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo_v3_fifo_core.sv
// Purpose : pointer, count and storage engine of stream_fifo_v3.
//           Plain push/pop interface; the caller qualifies push/pop.
// Ports   : clk_i, rst_i (async, active-high), flush_i (sync clear),
//           push_i / pop_i (qualified requests), data_i (write payload),
//           data_o (head entry, or data_i when bypassing an empty FIFO),
//           full_o (cnt == DEPTH), cnt_zero_o (cnt == 0),
//           usage_o (cnt modulo 2^ADDR_DEPTH).
module stream_fifo_v3_fifo_core
    import stream_fifo_v3_pkg::*;
#(
    parameter bit  FALL_THROUGH = 1'b0,
    parameter int  DEPTH        = 8,
    parameter type T            = logic [31:0],
    localparam int ADDR_DEPTH   = addr_depth(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  T                      data_i,
    output T                      data_o,
    output logic                  full_o,
    output logic                  cnt_zero_o,
    output logic [ADDR_DEPTH-1:0] usage_o
);

    localparam logic [ADDR_DEPTH-1:0] PTR_LAST = ADDR_DEPTH'(DEPTH - 1);
    localparam logic [ADDR_DEPTH:0]   CNT_FULL = (ADDR_DEPTH + 1)'(DEPTH);

    logic [ADDR_DEPTH-1:0] r_wr_ptr;
    logic [ADDR_DEPTH-1:0] r_rd_ptr;
    logic [ADDR_DEPTH:0]   r_cnt;

    logic w_full;
    logic w_cnt_zero;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    T     w_mem [DEPTH];
    T     w_head;

    assign w_full     = (r_cnt == CNT_FULL);
    assign w_cnt_zero = (r_cnt == '0);

    // A word that enters and leaves an empty fall-through FIFO in the same
    // cycle never touches storage: pointers and count stay put.
    assign w_bypass = FALL_THROUGH && w_cnt_zero && push_i && pop_i;

    // Flush wins over both requests; the extra full/empty gating keeps the
    // core safe even if a caller issues an unqualified request.
    assign w_push = push_i && !w_full     && !w_bypass && !flush_i;
    assign w_pop  = pop_i  && !w_cnt_zero && !w_bypass && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            // Explicit wrap so non-power-of-two depths work.
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // One register per entry; each entry loads only when the write pointer
    // selects it on a qualified push.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            T r_entry;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_entry <= '0;
                end else if (w_push && (r_wr_ptr == ADDR_DEPTH'(gi))) begin
                    r_entry <= data_i;
                end
            end

            assign w_mem[gi] = r_entry;
        end
    endgenerate

    assign w_head = w_mem[r_rd_ptr];

    assign data_o     = (FALL_THROUGH && w_cnt_zero) ? data_i : w_head;
    assign full_o     = w_full;
    assign cnt_zero_o = w_cnt_zero;
    assign usage_o    = r_cnt[ADDR_DEPTH-1:0];

endmodule

// File: rtl/stream_fifo_v3.sv
// Purpose : single-clock FIFO with valid/ready stream ports and
//           full/empty/usage status; optional zero-latency fall-through.
// Ports   : clk_i, rst_i (async, active-high), flush_i (sync clear),
//           testmode_i (DFT hook, functionally unused),
//           usage_o (entries modulo 2^ADDR_DEPTH), full_o, empty_o,
//           data_i / valid_i / ready_o  (write side),
//           data_o / valid_o / ready_i  (read side).
module stream_fifo_v3
    import stream_fifo_v3_pkg::*;
#(
    parameter bit  FALL_THROUGH = 1'b0,
    parameter int  DATA_WIDTH   = 32,
    parameter int  DEPTH        = 8,
    parameter type T            = logic [DATA_WIDTH-1:0],
    localparam int ADDR_DEPTH   = addr_depth(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic [ADDR_DEPTH-1:0] usage_o,
    output logic                  full_o,
    output logic                  empty_o,
    input  T                      data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output T                      data_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("stream_fifo_v3: DEPTH must be at least 1");
        end
        if ($bits(T) != DATA_WIDTH) begin : g_bad_width
            $error("stream_fifo_v3: $bits(T) must equal DATA_WIDTH");
        end
    endgenerate

    logic w_full;
    logic w_cnt_zero;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_unused;

    // testmode_i is a DFT hook only.
    assign w_unused = testmode_i;

    // In fall-through mode an incoming word makes the FIFO look non-empty.
    assign w_empty = w_cnt_zero & ~(FALL_THROUGH & valid_i);

    // ready_o comes from registered count only, never from valid_i/ready_i.
    assign ready_o = ~w_full;
    assign valid_o = ~w_empty;
    assign full_o  = w_full;
    assign empty_o = w_empty;

    assign w_push = valid_i & ready_o;
    assign w_pop  = ready_i & valid_o;

    stream_fifo_v3_fifo_core #(
        .FALL_THROUGH (FALL_THROUGH),
        .DEPTH        (DEPTH),
        .T            (T)
    ) u_core (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .push_i     (w_push),
        .pop_i      (w_pop),
        .data_i     (data_i),
        .data_o     (data_o),
        .full_o     (w_full),
        .cnt_zero_o (w_cnt_zero),
        .usage_o    (usage_o)
    );

endmodule

// File: tb/tb_stream_fifo_v3.sv
module tb_stream_fifo_v3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // a_: registered, DEPTH=4
    logic       a_flush = 0, a_valid = 0, a_ready = 0;
    logic [7:0] a_data = 0, a_data_o;
    logic [1:0] a_usage;
    logic       a_full, a_empty, a_ready_o, a_valid_o;

    // f_: fall-through, DEPTH=4
    logic       f_flush = 0, f_valid = 0, f_ready = 0;
    logic [7:0] f_data = 0, f_data_o;
    logic [1:0] f_usage;
    logic       f_full, f_empty, f_ready_o, f_valid_o;

    // t_: registered, DEPTH=3
    logic       t_flush = 0, t_valid = 0, t_ready = 0;
    logic [7:0] t_data = 0, t_data_o;
    logic [1:0] t_usage;
    logic       t_full, t_empty, t_ready_o, t_valid_o;

    // d_: registered, DEPTH=2
    logic       d_flush = 0, d_valid = 0, d_ready = 0;
    logic [7:0] d_data = 0, d_data_o;
    logic [0:0] d_usage;
    logic       d_full, d_empty, d_ready_o, d_valid_o;

    stream_fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .testmode_i(1'b0),
        .usage_o(a_usage), .full_o(a_full), .empty_o(a_empty),
        .data_i(a_data), .valid_i(a_valid), .ready_o(a_ready_o),
        .data_o(a_data_o), .valid_o(a_valid_o), .ready_i(a_ready));

    stream_fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_f (
        .clk_i(clk), .rst_i(rst), .flush_i(f_flush), .testmode_i(1'b0),
        .usage_o(f_usage), .full_o(f_full), .empty_o(f_empty),
        .data_i(f_data), .valid_i(f_valid), .ready_o(f_ready_o),
        .data_o(f_data_o), .valid_o(f_valid_o), .ready_i(f_ready));

    stream_fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) u_t (
        .clk_i(clk), .rst_i(rst), .flush_i(t_flush), .testmode_i(1'b0),
        .usage_o(t_usage), .full_o(t_full), .empty_o(t_empty),
        .data_i(t_data), .valid_i(t_valid), .ready_o(t_ready_o),
        .data_o(t_data_o), .valid_o(t_valid_o), .ready_i(t_ready));

    stream_fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(2)) u_d (
        .clk_i(clk), .rst_i(rst), .flush_i(d_flush), .testmode_i(1'b0),
        .usage_o(d_usage), .full_o(d_full), .empty_o(d_empty),
        .data_i(d_data), .valid_i(d_valid), .ready_o(d_ready_o),
        .data_o(d_data_o), .valid_o(d_valid_o), .ready_i(d_ready));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int        in_idx;
    int        out_cnt;
    int        m_cnt;
    bit        exp_push;
    bit        exp_pop;
    logic [7:0] q[$];

    initial begin
        // ---------------- reset state ----------------
        f_valid = 1'b1;
        f_data  = 8'h3C;
        #1;
        check("rst_empty",   a_empty,   1);
        check("rst_valid",   a_valid_o, 0);
        check("rst_full",    a_full,    0);
        check("rst_ready",   a_ready_o, 1);
        check("rst_usage",   a_usage,   0);
        check("rst_data",    a_data_o,  0);
        check("rst_ft_valid", f_valid_o, 1);
        check("rst_ft_data",  f_data_o,  8'h3C);
        f_valid = 1'b0;
        f_data  = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        #1;
        $display("reset released");

        // ---------------- registered fill and drain ----------------
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1;
            a_data  = 8'(8'h11 * (i + 1));
            tick();
            check("fill_head", a_data_o, 8'h11);
            check("fill_usage", a_usage, 32'((i + 1) % 4));
            $display("push %0h", a_data);
        end
        a_valid = 1'b0;
        #1;
        check("full_flag",  a_full,    1);
        check("full_ready", a_ready_o, 0);
        check("full_usage", a_usage,   0);
        check("full_valid", a_valid_o, 1);
        a_valid = 1'b1;
        a_data  = 8'h55;
        tick();
        a_valid = 1'b0;
        #1;
        check("drop_full",  a_full,   1);
        check("drop_head",  a_data_o, 8'h11);
        a_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("drain_data", a_data_o, 32'(8'h11 * (i + 1)));
            $display("pop %0h", a_data_o);
            tick();
        end
        a_ready = 1'b0;
        #1;
        check("drain_empty", a_empty, 1);
        check("drain_usage", a_usage, 0);

        // ---------------- flush priority ----------------
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1;
            a_data  = 8'(8'hA1 + i);
            tick();
        end
        a_valid = 1'b0;
        #1;
        check("pre_flush_usage", a_usage, 3);
        a_flush = 1'b1;
        a_valid = 1'b1;
        a_data  = 8'hA4;
        a_ready = 1'b1;
        #1;
        check("flush_cycle_usage", a_usage, 3);
        tick();
        a_flush = 1'b0;
        a_valid = 1'b0;
        a_ready = 1'b0;
        #1;
        check("flush_empty", a_empty,   1);
        check("flush_usage", a_usage,   0);
        check("flush_ready", a_ready_o, 1);
        a_valid = 1'b1;
        a_data  = 8'hB1;
        tick();
        a_valid = 1'b0;
        #1;
        check("post_flush_data",  a_data_o, 8'hB1);
        check("post_flush_usage", a_usage,  1);
        $display("flush done, first word %0h", a_data_o);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        #1;
        check("post_flush_drain", a_empty, 1);

        // ---------------- fall-through bypass ----------------
        f_valid = 1'b1;
        f_data  = 8'hA5;
        f_ready = 1'b1;
        #1;
        check("ft_valid", f_valid_o, 1);
        check("ft_data",  f_data_o,  8'hA5);
        check("ft_ready", f_ready_o, 1);
        tick();
        f_valid = 1'b0;
        f_ready = 1'b0;
        #1;
        check("ft_empty_after", f_empty, 1);
        check("ft_usage_after", f_usage, 0);
        $display("bypass A5");
        f_valid = 1'b1;
        f_data  = 8'h5A;
        tick();
        f_valid = 1'b0;
        #1;
        check("ft_store_usage", f_usage,   1);
        check("ft_store_data",  f_data_o,  8'h5A);
        check("ft_store_valid", f_valid_o, 1);
        f_valid = 1'b1;
        f_data  = 8'h77;
        f_ready = 1'b1;
        #1;
        check("ft_nonempty_head", f_data_o, 8'h5A);
        tick();
        f_valid = 1'b0;
        f_ready = 1'b0;
        #1;
        check("ft_swap_usage", f_usage,  1);
        check("ft_swap_data",  f_data_o, 8'h77);
        f_ready = 1'b1;
        tick();
        f_ready = 1'b0;
        #1;
        check("ft_final_empty", f_empty, 1);

        // ---------------- DEPTH=3 wrap with toggling ready ----------------
        in_idx  = 0;
        out_cnt = 0;
        m_cnt   = 0;
        for (int cyc = 0; cyc < 40 && out_cnt < 10; cyc++) begin
            t_valid = (in_idx < 10);
            t_data  = 8'(in_idx + 1);
            t_ready = (cyc % 2 == 1);
            #1;
            check("wrap_ready", t_ready_o, (m_cnt != 3));
            check("wrap_valid", t_valid_o, (m_cnt != 0));
            check("wrap_usage", t_usage,   32'(m_cnt % 4));
            if (m_cnt > 0) begin
                check("wrap_data", t_data_o, q[0]);
            end
            exp_push = t_valid && (m_cnt < 3);
            exp_pop  = t_ready && (m_cnt > 0);
            tick();
            if (exp_pop) begin
                $display("wrap pop %0h", q[0]);
                void'(q.pop_front());
                out_cnt++;
            end
            if (exp_push) begin
                q.push_back(t_data);
                in_idx++;
            end
            m_cnt = m_cnt + (exp_push ? 1 : 0) - (exp_pop ? 1 : 0);
        end
        t_valid = 1'b0;
        t_ready = 1'b0;
        #1;
        check("wrap_all_out", out_cnt, 10);
        check("wrap_empty",   t_empty, 1);

        // ---------------- DEPTH=2 full with push and pop ----------------
        d_valid = 1'b1;
        d_data  = 8'd1;
        tick();
        d_data  = 8'd2;
        tick();
        d_valid = 1'b0;
        #1;
        check("d2_full", d_full, 1);
        d_valid = 1'b1;
        d_data  = 8'd3;
        d_ready = 1'b1;
        #1;
        check("d2_head",  d_data_o,  1);
        check("d2_ready", d_ready_o, 0);
        tick();
        d_valid = 1'b0;
        d_ready = 1'b0;
        #1;
        check("d2_usage", d_usage,  1);
        check("d2_next",  d_data_o, 2);
        check("d2_nfull", d_full,   0);
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
        #1;
        check("d2_dropped", d_empty, 1);
        $display("d2 push/pop while full done");

        // ---------------- reset mid-stream ----------------
        a_valid = 1'b1;
        a_data  = 8'h61;
        tick();
        a_data  = 8'h62;
        tick();
        a_valid = 1'b0;
        #1;
        check("mid_usage", a_usage,  2);
        check("mid_head",  a_data_o, 8'h61);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", a_valid_o, 0);
        check("mid_rst_data",  a_data_o,  0);
        check("mid_rst_usage", a_usage,   0);
        tick();
        rst = 1'b0;
        a_valid = 1'b1;
        a_data  = 8'h05;
        tick();
        a_valid = 1'b0;
        #1;
        check("post_rst_data",  a_data_o,  8'h05);
        check("post_rst_valid", a_valid_o, 1);
        $display("post reset word %0h", a_data_o);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
